// File: rtl/simd_ctrl_dispatch.sv
// simd_ctrl_dispatch
//   Command sequencer between the scalar core's control-write port and the
//   vector core's command input. Control words are buffered in a DEPTH-entry
//   FIFO and issued one at a time over a valid/ready handshake. A FENCE word
//   (opcode OPC_FENCE in the top 4 bits) is never forwarded. Instead, it stalls
//   further issue until the vector core reports idle.
//
// Ports
//   CLK            system clock
//   RESET_N        asynchronous active-low reset, synchronous release
//   CONTROL_DATA   control word from the scalar core
//   CONTROL_WR     control write strobe (one word per cycle)
//   CORE_BUSY      FIFO full; writes while high are dropped
//   VEC_CMD        command to the vector core
//   VEC_CMD_VALID  VEC_CMD is valid
//   VEC_CMD_READY  vector core accepts the command
//   VEC_IDLE       vector core has no command in flight
//   SIMD_IDLE      whole dispatch path (FIFO, sequencer, vector core) is idle
//   FIFO_COUNT     current FIFO occupancy
//
// Optional feature (macro SIMD_DISPATCH_ERR_EN)
//   ERR_OVF        sticky flag, set by any CONTROL_WR while CORE_BUSY=1
//   ERR_CLR        clears ERR_OVF; a set in the same cycle wins
module simd_ctrl_dispatch #(
  parameter int          DATA_WIDTH = 64,
  parameter int          DEPTH      = 4,
  parameter logic [3:0]  OPC_FENCE  = 4'hF
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [DATA_WIDTH-1:0]   CONTROL_DATA,
  input  logic                    CONTROL_WR,
  output logic                    CORE_BUSY,
  output logic [DATA_WIDTH-1:0]   VEC_CMD,
  output logic                    VEC_CMD_VALID,
  input  logic                    VEC_CMD_READY,
  input  logic                    VEC_IDLE,
  output logic                    SIMD_IDLE,
  output logic [$clog2(DEPTH):0]  FIFO_COUNT
`ifdef SIMD_DISPATCH_ERR_EN
  ,
  output logic                    ERR_OVF,
  input  logic                    ERR_CLR
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FENCE = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  // Sequencer
  state_t                state_reg;
  state_t                state_next;
  logic                  valid_reg;
  logic                  valid_next;
  logic [DATA_WIDTH-1:0] cmd_reg;
  logic [DATA_WIDTH-1:0] cmd_next;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic                  head_is_fence;

  assign full          = (count_reg == CNT_W'(DEPTH));
  assign empty         = (count_reg == '0);
  // Full is taken from the registered count, so a write while full is lost
  // even when the same cycle pops an entry.
  assign push          = CONTROL_WR && !full;
  assign head          = mem[rd_ptr_reg];
  assign head_is_fence = (head[DATA_WIDTH-1 -: 4] == OPC_FENCE);

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= CONTROL_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= S_IDLE;
      valid_reg <= 1'b0;
      cmd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Pops are decided from the registered count only, so a word written this
  // cycle is never issued in the same cycle (no fall-through).
  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    cmd_next   = cmd_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_is_fence) begin
            state_next = S_FENCE;
          end else begin
            cmd_next   = head;
            valid_next = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // VALID is always high here, so READY alone completes the handshake.
        if (VEC_CMD_READY) begin
          if (!empty) begin
            pop = 1'b1;
            if (head_is_fence) begin
              valid_next = 1'b0;
              state_next = S_FENCE;
            end else begin
              cmd_next = head;
            end
          end else begin
            valid_next = 1'b0;
            state_next = S_IDLE;
          end
        end
      end
      S_FENCE: begin
        // Only reachable from a previous cycle, so at least one cycle is
        // always spent here before VEC_IDLE can release the fence.
        if (VEC_IDLE) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

`ifdef SIMD_DISPATCH_ERR_EN
  logic err_ovf_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_ovf_reg <= 1'b0;
    end else if (CONTROL_WR && full) begin
      err_ovf_reg <= 1'b1;
    end else if (ERR_CLR) begin
      err_ovf_reg <= 1'b0;
    end
  end

  assign ERR_OVF = err_ovf_reg;
`endif

  assign CORE_BUSY     = full;
  assign VEC_CMD       = cmd_reg;
  assign VEC_CMD_VALID = valid_reg;
  assign FIFO_COUNT    = count_reg;
  assign SIMD_IDLE     = empty && (state_reg == S_IDLE) && !valid_reg && VEC_IDLE;

endmodule
